systolic_pe: RTL and testbench
==============================

Name: systolic_pe

Overview:
Parametrised output-stationary processing element for the FFN systolic array. It multiplies signed operands, accumulates dot products framed by first/last markers, and forwards operands and framing one cycle later to east/south neighbours. It has optional multiplier pipelining, saturating or wrapping accumulation, and a single-entry result register with a valid/ready drain. It sits at every array node and feeds the column drain chain.

Parameters:
DATA_WIDTH, 8, signed operand width (>=2)
ACC_WIDTH, 20, signed accumulator/result width (>=2*DATA_WIDTH)
PIPE_MULT, 0, extra register stages after multiplier (0 or 1)
SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
in_valid_i  in  1  operand beat valid
first_i  in  1  beat is first term of a dot product
last_i  in  1  beat is last term of a dot product
a_i  in  DATA_WIDTH  signed operand A (from west)
b_i  in  DATA_WIDTH  signed operand B (from north)
a_o  out  DATA_WIDTH  registered A to east
b_o  out  DATA_WIDTH  registered B to south
fwd_valid_o, fwd_first_o, fwd_last_o  out  1 each  registered framing to neighbours
res_o  out  ACC_WIDTH  completed dot product
res_valid_o  out  1  res_o holds unread result
res_ready_i  in  1  drain accepts result
busy_o  out  1  accumulation in progress (state ACC)
ovf_o  out  1  sticky: saturation/wrap occurred in current or held result
lost_o  out  1  sticky: unread result overwritten

Behaviour:
- Reset: all outputs 0; accumulator 0; state IDLE; multiplier pipe valid 0. Reset mid-frame discards everything.
- Forwarding: a_o/b_o/fwd_* <= inputs every clock, regardless of in_valid_i (1-cycle latency, no stall).
- Product: full 2*DATA_WIDTH signed product, sign-extended to ACC_WIDTH+1 for the sum. With PIPE_MULT=1, the product plus first/last/valid are registered once more.
- Latency: input beat at edge t updates the accumulator at t+1+PIPE_MULT. A last beat sets res_valid_o at the same edge.
- FSM, evaluated on product-valid beats only:
  - IDLE: first, or any valid beat (missing first is treated as first) -> acc = product, ovf cleared; to ACC unless last.
  - ACC: beat without first -> acc += product. Beat with first -> restart (acc = product, ovf cleared, prior partial dropped, no flag).
  - last (any state) -> res_o = final sum, res_valid_o = 1, ovf_o reflects the frame; go to IDLE.
  - first && last on the same beat -> single-term result.
- Arithmetic: compute an ACC_WIDTH+1 sum.
  - SATURATE=1: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and set ovf.
  - SATURATE=0: truncate and set ovf on sign overflow.
  - ovf is sticky until the next frame start.
- Drain: res_valid_o && res_ready_i at an edge clears res_valid_o. If a new result completes at the same edge, it loads and res_valid_o stays 1 (no loss).
  - New result while res_valid_o=1 and !res_ready_i: overwrite res_o, set lost_o.
  - lost_o clears only on reset.
- busy_o = (state == ACC).

Decomposition:
- Package pe_pkg: state enum {IDLE, ACC}; sat_add function (ACC_WIDTH+1 sum -> clamped value + ovf flag); PIPE_MULT range constant check.
- Sub-module pe_mult_pipe: signed multiply plus 0/1 register stage carrying valid/first/last.

Test Plan:
- Defaults, PIPE_MULT=0: beats (3,4 first),(-2,5),(7,-1 last) -> res_o=-5, res_valid_o at edge t+1 after last, ovf_o=0, busy_o high during frame.
- PIPE_MULT=1: same stream -> res_o=-5 one cycle later; a_o/b_o still 1-cycle delayed copies.
- ACC_WIDTH=16, DATA_WIDTH=8, SATURATE=1: (-128,-128 first),(-128,-128 last) -> res_o=32767, ovf_o=1. Same with SATURATE=0 -> res_o=-32768, ovf_o=1.
- res_ready_i=0, two single-beat frames (2,3),(4,5) -> res_o=20, lost_o=1. Repeat with ready asserted on the completion edge -> res_o=20, lost_o=0, res_valid_o stays 1.
- Mid-frame first: (1,1 first),(2,2),(3,3 first),(1,1 last) -> res_o=10. Beat (6,6 last) from IDLE without first -> res_o=36.
- Assert rstn low mid-frame, then release -> all outputs 0, state IDLE; the next frame (5,5 first/last) -> res_o=25.

Source files
------------

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types, constants and arithmetic helpers for the systolic PE
package pe_pkg;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  // Widest accumulator the clamp helper handles; ACC_WIDTH must stay below this.
  localparam int MAX_W = 63;
  localparam logic signed [MAX_W:0] SUM_ONE = {{MAX_W{1'b0}}, 1'b1};

  typedef struct packed {
    logic signed [MAX_W-1:0] value;
    logic                    ovf;
  } sat_t;

  function automatic logic pipe_mult_ok(input int p);
    return (p == 0) || (p == 1);
  endfunction

  // Reduce a sign-extended (acc_w+1)-bit sum to acc_w bits, clamping or wrapping.
  function automatic sat_t sat_add(input logic signed [MAX_W:0] sum, input int acc_w,
                                   input logic saturate);
    logic signed [MAX_W:0] hi;
    logic signed [MAX_W:0] lo;
    logic signed [MAX_W:0] wrapped;
    int sh;
    sat_t r;
    hi = (SUM_ONE <<< (acc_w - 1)) - SUM_ONE;
    lo = -hi - SUM_ONE;
    sh = MAX_W + 1 - acc_w;
    wrapped = (sum <<< sh) >>> sh;
    r.ovf = (sum > hi) || (sum < lo);
    if (saturate && (sum > hi)) begin
      r.value = hi[MAX_W-1:0];
    end else if (saturate && (sum < lo)) begin
      r.value = lo[MAX_W-1:0];
    end else begin
      r.value = wrapped[MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_mult_pipe.sv
// rtl/pe_mult_pipe.sv - signed multiplier with optional register stage carrying beat framing
module pe_mult_pipe
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PIPE_MULT  = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      valid,
  input  logic                      first,
  input  logic                      last,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [2*DATA_WIDTH-1:0]   prod,
  output logic                      prod_valid,
  output logic                      prod_first,
  output logic                      prod_last
);

  logic [2*DATA_WIDTH-1:0] mult;

  // Low 2*DATA_WIDTH bits of the sign-extended product equal the signed product.
  assign mult = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} * {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};

  if (PIPE_MULT == 0) begin : g_comb
    logic unused_clk;
    assign unused_clk = clk ^ rstn;
    assign prod       = mult;
    assign prod_valid = valid;
    assign prod_first = first;
    assign prod_last  = last;
  end else begin : g_reg
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        prod       <= '0;
        prod_valid <= 1'b0;
        prod_first <= 1'b0;
        prod_last  <= 1'b0;
      end else begin
        prod       <= mult;
        prod_valid <= valid;
        prod_first <= first;
        prod_last  <= last;
      end
    end
  end

endmodule

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - output-stationary MAC node with operand forwarding and result drain
module systolic_pe
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int PIPE_MULT  = 0,
  parameter int SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid_i,
  input  logic                  first_i,
  input  logic                  last_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic                  fwd_valid_o,
  output logic                  fwd_first_o,
  output logic                  fwd_last_o,
  output logic [ACC_WIDTH-1:0]  res_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic                  busy_o,
  output logic                  ovf_o,
  output logic                  lost_o
);

  localparam int PW  = 2 * DATA_WIDTH;
  localparam int EXT = MAX_W - ACC_WIDTH;

  if (!pipe_mult_ok(PIPE_MULT)) begin : g_bad_pipe_mult
    $error("systolic_pe: PIPE_MULT must be 0 or 1");
  end

  state_t               state_q;
  state_t               state_d;
  logic [PW-1:0]        prod;
  logic                 p_valid;
  logic                 p_first;
  logic                 p_last;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic                 ovf_d;
  logic [ACC_WIDTH:0]   prod_ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 frame_start;
  sat_t                 sat;
  logic                 unused_sat_hi;

  pe_mult_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .PIPE_MULT  (PIPE_MULT)
  ) u_mult (
    .clk        (clk),
    .rstn       (rstn),
    .valid      (in_valid_i),
    .first      (first_i),
    .last       (last_i),
    .a          (a_i),
    .b          (b_i),
    .prod       (prod),
    .prod_valid (p_valid),
    .prod_first (p_first),
    .prod_last  (p_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_o         <= '0;
      b_o         <= '0;
      fwd_valid_o <= 1'b0;
      fwd_first_o <= 1'b0;
      fwd_last_o  <= 1'b0;
    end else begin
      a_o         <= a_i;
      b_o         <= b_i;
      fwd_valid_o <= in_valid_i;
      fwd_first_o <= first_i;
      fwd_last_o  <= last_i;
    end
  end

  // A beat arriving in IDLE opens a frame even when first is missing.
  always_comb begin
    prod_ext    = {{(ACC_WIDTH + 1 - PW){prod[PW-1]}}, prod};
    sum         = {acc_q[ACC_WIDTH-1], acc_q} + prod_ext;
    sat         = sat_add({{EXT{sum[ACC_WIDTH]}}, sum}, ACC_WIDTH, SATURATE != 0);
    frame_start = p_first || (state_q == IDLE);
    if (frame_start) begin
      acc_d = prod_ext[ACC_WIDTH-1:0];
      ovf_d = 1'b0;
    end else begin
      acc_d = sat.value[ACC_WIDTH-1:0];
      ovf_d = ovf_o | sat.ovf;
    end
  end

  assign unused_sat_hi = ^sat.value[MAX_W-1:ACC_WIDTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (p_valid) begin
      state_d = p_last ? IDLE : ACC;
    end
  end

  always_comb begin
    busy_o = (state_q == ACC);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q       <= '0;
      ovf_o       <= 1'b0;
      res_o       <= '0;
      res_valid_o <= 1'b0;
      lost_o      <= 1'b0;
    end else begin
      if (p_valid) begin
        acc_q <= acc_d;
        ovf_o <= ovf_d;
      end
      // A completing frame always loads; only an undrained prior result is lost.
      if (p_valid && p_last) begin
        res_o       <= acc_d;
        res_valid_o <= 1'b1;
        if (res_valid_o && !res_ready_i) begin
          lost_o <= 1'b1;
        end
      end else if (res_valid_o && res_ready_i) begin
        res_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_pe.sv
// tb/tb_systolic_pe.sv - three PE configurations driven in parallel against a frame-level model
module tb_systolic_pe;

  localparam int CW [3] = '{20, 16, 16};
  localparam int CP [3] = '{0, 1, 0};
  localparam int CS [3] = '{1, 0, 1};

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic       first = 1'b0;
  logic       last = 1'b0;
  logic       res_ready = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic [7:0]  ao [3];
  logic [7:0]  bo [3];
  logic        fv [3];
  logic        ff [3];
  logic        fl [3];
  logic        rv [3];
  logic        bsy [3];
  logic        ov [3];
  logic        lst [3];
  logic [19:0] res0;
  logic [15:0] res1;
  logic [15:0] res2;
  longint      obs_res [3];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit     v;
    bit     f;
    bit     l;
    longint p;
  } beat_t;

  longint m_acc [3];
  longint m_res [3];
  bit     m_busy [3];
  bit     m_ovf [3];
  bit     m_rv [3];
  bit     m_lost [3];
  beat_t  prev;
  longint e_a, e_b;
  bit     e_v, e_f, e_l;

  always #5 clk = ~clk;

  systolic_pe #(.DATA_WIDTH(8), .ACC_WIDTH(20), .PIPE_MULT(0), .SATURATE(1)) u0 (
    .clk(clk), .rstn(rstn), .in_valid_i(in_valid), .first_i(first), .last_i(last),
    .a_i(a), .b_i(b), .a_o(ao[0]), .b_o(bo[0]), .fwd_valid_o(fv[0]), .fwd_first_o(ff[0]),
    .fwd_last_o(fl[0]), .res_o(res0), .res_valid_o(rv[0]), .res_ready_i(res_ready),
    .busy_o(bsy[0]), .ovf_o(ov[0]), .lost_o(lst[0]));

  systolic_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .PIPE_MULT(1), .SATURATE(0)) u1 (
    .clk(clk), .rstn(rstn), .in_valid_i(in_valid), .first_i(first), .last_i(last),
    .a_i(a), .b_i(b), .a_o(ao[1]), .b_o(bo[1]), .fwd_valid_o(fv[1]), .fwd_first_o(ff[1]),
    .fwd_last_o(fl[1]), .res_o(res1), .res_valid_o(rv[1]), .res_ready_i(res_ready),
    .busy_o(bsy[1]), .ovf_o(ov[1]), .lost_o(lst[1]));

  systolic_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .PIPE_MULT(0), .SATURATE(1)) u2 (
    .clk(clk), .rstn(rstn), .in_valid_i(in_valid), .first_i(first), .last_i(last),
    .a_i(a), .b_i(b), .a_o(ao[2]), .b_o(bo[2]), .fwd_valid_o(fv[2]), .fwd_first_o(ff[2]),
    .fwd_last_o(fl[2]), .res_o(res2), .res_valid_o(rv[2]), .res_ready_i(res_ready),
    .busy_o(bsy[2]), .ovf_o(ov[2]), .lost_o(lst[2]));

  always_comb begin
    obs_res[0] = longint'($signed(res0));
    obs_res[1] = longint'($signed(res1));
    obs_res[2] = longint'($signed(res2));
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_res[i] = 0; m_busy[i] = 0; m_ovf[i] = 0; m_rv[i] = 0; m_lost[i] = 0;
    end
    prev = '{default: 0};
    e_a = 0; e_b = 0; e_v = 0; e_f = 0; e_l = 0;
  endtask

  task automatic model_apply(input int i, input beat_t bt, input bit ready);
    longint lim, s;
    bit done;
    lim = longint'(1) << (CW[i] - 1);
    done = 0;
    if (bt.v) begin
      if (bt.f || !m_busy[i]) begin
        m_acc[i] = bt.p;
        m_ovf[i] = 0;
      end else begin
        s = m_acc[i] + bt.p;
        if (s >= lim || s < -lim) begin
          m_ovf[i] = 1;
          if (CS[i] != 0) s = (s > 0) ? lim - 1 : -lim;
          else s = ((s + lim) % (2 * lim) + 2 * lim) % (2 * lim) - lim;
        end
        m_acc[i] = s;
      end
      if (bt.l) begin
        if (m_rv[i] && !ready) m_lost[i] = 1;
        m_res[i] = m_acc[i];
        m_rv[i] = 1;
        m_busy[i] = 0;
        done = 1;
      end else begin
        m_busy[i] = 1;
      end
    end
    if (!done && m_rv[i] && ready) m_rv[i] = 0;
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.res_o", i), obs_res[i], m_res[i]);
      chk($sformatf("u%0d.res_valid_o", i), longint'(rv[i]), longint'(m_rv[i]));
      chk($sformatf("u%0d.lost_o", i), longint'(lst[i]), longint'(m_lost[i]));
      chk($sformatf("u%0d.ovf_o", i), longint'(ov[i]), longint'(m_ovf[i]));
      chk($sformatf("u%0d.busy_o", i), longint'(bsy[i]), longint'(m_busy[i]));
      chk($sformatf("u%0d.a_o", i), longint'($signed(ao[i])), e_a);
      chk($sformatf("u%0d.b_o", i), longint'($signed(bo[i])), e_b);
      chk($sformatf("u%0d.fwd_valid_o", i), longint'(fv[i]), longint'(e_v));
      chk($sformatf("u%0d.fwd_first_o", i), longint'(ff[i]), longint'(e_f));
      chk($sformatf("u%0d.fwd_last_o", i), longint'(fl[i]), longint'(e_l));
    end
  endtask

  task automatic step(input bit v, input bit f, input bit l, input int av, input int bv,
                      input bit rdy);
    beat_t cur;
    in_valid = v; first = f; last = l; a = av[7:0]; b = bv[7:0]; res_ready = rdy;
    cur.v = v; cur.f = f; cur.l = l;
    cur.p = longint'($signed(a)) * longint'($signed(b));
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_apply(i, (CP[i] != 0) ? prev : cur, rdy);
    prev = cur;
    e_a = longint'($signed(a)); e_b = longint'($signed(b));
    e_v = v; e_f = f; e_l = l;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    in_valid = 0; first = 0; last = 0; a = '0; b = '0; res_ready = 0;
    rstn = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rstn = 1'b1;

    // Three-term dot product
    step(1, 1, 0, 3, 4, 1);
    chk("plan.busy_mid", longint'(bsy[0]), 1);
    step(1, 0, 0, -2, 5, 1);
    step(1, 0, 1, 7, -1, 1);
    chk("plan.dot_pm0", obs_res[0], -5);
    chk("plan.dot_pm0_valid", longint'(rv[0]), 1);
    chk("plan.dot_pm0_ovf", longint'(ov[0]), 0);
    step(0, 0, 0, 0, 0, 1);
    chk("plan.dot_pm1", obs_res[1], -5);

    // Overflow: clamp, wrap, and no overflow at 20 bits
    step(1, 1, 0, -128, -128, 1);
    step(1, 0, 1, -128, -128, 1);
    chk("plan.sat_res", obs_res[2], 32767);
    chk("plan.sat_ovf", longint'(ov[2]), 1);
    chk("plan.wide_res", obs_res[0], 32768);
    step(0, 0, 0, 0, 0, 1);
    chk("plan.wrap_res", obs_res[1], -32768);
    chk("plan.wrap_ovf", longint'(ov[1]), 1);

    // Unread result overwritten
    do_reset();
    step(1, 1, 1, 2, 3, 0);
    step(1, 1, 1, 4, 5, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("plan.lost_res", obs_res[0], 20);
    chk("plan.lost_flag", longint'(lst[0]), 1);

    // Drain on the completion edge loses nothing
    do_reset();
    step(1, 1, 1, 2, 3, 0);
    step(1, 1, 1, 4, 5, 1);
    chk("plan.drain_res", obs_res[0], 20);
    chk("plan.drain_lost", longint'(lst[0]), 0);
    chk("plan.drain_valid", longint'(rv[0]), 1);
    step(0, 0, 0, 0, 0, 0);

    // Restart mid-frame, then a last beat from IDLE without first
    step(1, 1, 0, 1, 1, 1);
    step(1, 0, 0, 2, 2, 1);
    step(1, 1, 0, 3, 3, 1);
    step(1, 0, 1, 1, 1, 1);
    chk("plan.restart", obs_res[0], 10);
    step(1, 0, 1, 6, 6, 1);
    chk("plan.no_first", obs_res[0], 36);
    step(0, 0, 0, 0, 0, 1);
    chk("plan.no_first_pm1", obs_res[1], 36);

    // Reset in the middle of a frame
    step(1, 1, 0, 5, 5, 1);
    step(1, 0, 0, 5, 5, 1);
    do_reset();
    chk("plan.rst_busy", longint'(bsy[0]), 0);
    chk("plan.rst_res", obs_res[0], 0);
    step(1, 1, 1, 5, 5, 1);
    chk("plan.post_rst", obs_res[0], 25);
    step(0, 0, 0, 0, 0, 1);
    chk("plan.post_rst_pm1", obs_res[1], 25);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
